// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss-service (refill) engine.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_FETCH = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } refill_state_t;

    function automatic int block_size(input int bits);
        return int'(32'd1 << bits);
    endfunction

    // Block-aligned base address: word-offset bits forced to zero.
    function automatic logic [31:0] block_base(input logic [31:0] addr, input int bits);
        logic [31:0] mask;
        mask = ~((32'd1 << bits) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/cache_refill_buffer.sv
// Block staging buffer: one indexed write port, whole block visible in parallel.
module cache_refill_buffer
    import cache_pkg::*;
#(
    parameter int DATA_BITS  = 32,
    parameter int BLOCK_BITS = 2,
    localparam int BLOCK_SIZE = block_size(BLOCK_BITS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_wr_en,
    input  logic [BLOCK_BITS-1:0] i_wr_idx,
    input  logic [DATA_BITS-1:0]  i_wr_data,
    output logic [DATA_BITS-1:0]  o_rd_data [BLOCK_SIZE-1:0]
);

    logic [DATA_BITS-1:0] r_words [BLOCK_SIZE-1:0];

    // Word storage, cleared on reset, otherwise kept until overwritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                r_words[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_words[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_words;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-service engine: single-word write-through and whole-block read refill
// between the cache and a word-wide memory port.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int HOLD_CYCLES      = 2,
    localparam int BLOCK_SIZE      = block_size(BLOCK_BITS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [RAM_ADDRESS_BITS-1:0] prop_address,
    input  logic                        prop_read_en,
    input  logic [DATA_BITS-1:0]        prop_write_data,
    input  logic                        prop_write_en,
    output logic                        ram_valid,
    output logic [DATA_BITS-1:0]        ram_data [BLOCK_SIZE-1:0],
    output logic                        busy,
    output logic [RAM_ADDRESS_BITS-1:0] mem_address,
    output logic                        mem_read_en,
    output logic                        mem_write_en,
    output logic [DATA_BITS-1:0]        mem_write_data,
    input  logic                        mem_ready,
    input  logic                        mem_rvalid,
    input  logic [DATA_BITS-1:0]        mem_rdata
);

    localparam int CNT_W  = BLOCK_BITS + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    refill_state_t               r_state;
    logic [RAM_ADDRESS_BITS-1:0] r_base;
    logic [RAM_ADDRESS_BITS-1:0] r_mem_address;
    logic [DATA_BITS-1:0]        r_mem_write_data;
    logic                        r_mem_read_en;
    logic                        r_mem_write_en;
    logic                        r_ram_valid;
    logic                        r_busy;
    logic [CNT_W-1:0]            r_req_cnt;
    logic [CNT_W-1:0]            r_rsp_cnt;
    logic [HOLD_W-1:0]           r_hold_cnt;

    logic [RAM_ADDRESS_BITS-1:0] w_prop_base;
    logic [CNT_W-1:0]            w_req_next;
    logic [RAM_ADDRESS_BITS-1:0] w_next_addr;
    logic                        w_rsp_take;

    assign w_prop_base = RAM_ADDRESS_BITS'(block_base(32'(prop_address), BLOCK_BITS));
    assign w_req_next  = r_req_cnt + CNT_W'(1);
    assign w_next_addr = r_base | RAM_ADDRESS_BITS'(w_req_next[BLOCK_BITS-1:0]);
    // Only responses to already-accepted requests are stored; strays are dropped.
    assign w_rsp_take  = (r_state == ST_FETCH) && mem_rvalid && (r_rsp_cnt < r_req_cnt);

    // Refill sequencer; every memory-side and cache-side output is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_base           <= '0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_read_en    <= 1'b0;
            r_mem_write_en   <= 1'b0;
            r_ram_valid      <= 1'b0;
            r_busy           <= 1'b0;
            r_req_cnt        <= '0;
            r_rsp_cnt        <= '0;
            r_hold_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (prop_write_en) begin
                        r_state          <= ST_WRITE;
                        r_busy           <= 1'b1;
                        r_mem_write_en   <= 1'b1;
                        r_mem_address    <= prop_address;
                        r_mem_write_data <= prop_write_data;
                    end else if (prop_read_en) begin
                        r_state       <= ST_FETCH;
                        r_busy        <= 1'b1;
                        r_mem_read_en <= 1'b1;
                        r_base        <= w_prop_base;
                        r_mem_address <= w_prop_base;
                        r_req_cnt     <= '0;
                        r_rsp_cnt     <= '0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        r_state        <= ST_IDLE;
                        r_busy         <= 1'b0;
                        r_mem_write_en <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (r_mem_read_en && mem_ready) begin
                        r_req_cnt <= w_req_next;
                        if (r_req_cnt == CNT_W'(BLOCK_SIZE - 1)) begin
                            r_mem_read_en <= 1'b0;
                        end else begin
                            r_mem_address <= w_next_addr;
                        end
                    end
                    if (w_rsp_take) begin
                        r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
                        if (r_rsp_cnt == CNT_W'(BLOCK_SIZE - 1)) begin
                            r_state     <= ST_DONE;
                            r_ram_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_HOLD;
                    r_ram_valid <= 1'b0;
                    r_hold_cnt  <= '0;
                end
                ST_HOLD: begin
                    // Gives the cache time to register ram_valid and fill the line.
                    if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_busy         <= 1'b0;
                    r_mem_read_en  <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    r_ram_valid    <= 1'b0;
                end
            endcase
        end
    end

    cache_refill_buffer #(
        .DATA_BITS  (DATA_BITS),
        .BLOCK_BITS (BLOCK_BITS)
    ) u_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_rsp_take),
        .i_wr_idx  (r_rsp_cnt[BLOCK_BITS-1:0]),
        .i_wr_data (mem_rdata),
        .o_rd_data (ram_data)
    );

    assign ram_valid      = r_ram_valid;
    assign busy           = r_busy;
    assign mem_address    = r_mem_address;
    assign mem_read_en    = r_mem_read_en;
    assign mem_write_en   = r_mem_write_en;
    assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed requests, queued expectations,
// a behavioural memory responder and an output monitor.
module tb_cache_refill_ctrl;

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    logic        clk;
    logic        reset_n;
    logic [9:0]  prop_address;
    logic        prop_read_en;
    logic [31:0] prop_write_data;
    logic        prop_write_en;
    logic        ram_valid;
    logic [31:0] ram_data [3:0];
    logic        busy;
    logic [9:0]  mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    int          valid_cnt = 0;
    int          valid_cyc = -1;
    logic [31:0] mem [0:1023];
    req_t        exp_req [$];
    logic [127:0] exp_blk [$];
    logic        ready_q [$];
    rsp_t        pend [$];

    cache_refill_ctrl #(
        .RAM_ADDRESS_BITS (10),
        .DATA_BITS        (32),
        .BLOCK_BITS       (2),
        .HOLD_CYCLES      (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .prop_address    (prop_address),
        .prop_read_en    (prop_read_en),
        .prop_write_data (prop_write_data),
        .prop_write_en   (prop_write_en),
        .ram_valid       (ram_valid),
        .ram_data        (ram_data),
        .busy            (busy),
        .mem_address     (mem_address),
        .mem_read_en     (mem_read_en),
        .mem_write_en    (mem_write_en),
        .mem_write_data  (mem_write_data),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_read(input logic [9:0] base, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back('{wr: 1'b0, addr: base + 10'(i), data: 32'h0});
        end
        exp_blk.push_back(blk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_blk.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("wait_idle_bound", 64'(n < 100), 64'(1));
    endtask

    task automatic chk_block_zero(input string nm);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s[%0d]", nm, i), 64'(ram_data[i]), 64'h0);
        end
    endtask

    // Memory model: accepts at mid-cycle, answers in order after lat cycles.
    initial begin
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_read_en && mem_ready) begin
                pend.push_back('{due: cyc + lat, d: mem[mem_address]});
            end
            @(posedge clk);
            #1;
            mem_ready = (ready_q.size() != 0) ? ready_q.pop_front() : 1'b1;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend[0].d;
                void'(pend.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
    end

    // Monitor: checks every presented request and every delivered block.
    initial begin
        logic [127:0] b;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (mem_read_en || mem_write_en) begin
                    if (exp_req.size() == 0) begin
                        chk("unexpected_mem_req", 64'({mem_write_en, mem_read_en}), 64'h0);
                    end else begin
                        chk("mem_write_en", 64'(mem_write_en), 64'(exp_req[0].wr));
                        chk("mem_read_en", 64'(mem_read_en), 64'(!exp_req[0].wr));
                        chk("mem_address", 64'(mem_address), 64'(exp_req[0].addr));
                        if (exp_req[0].wr) begin
                            chk("mem_write_data", 64'(mem_write_data), 64'(exp_req[0].data));
                        end
                        if (mem_ready) begin
                            void'(exp_req.pop_front());
                            acc_cnt++;
                        end
                    end
                end
                if (ram_valid) begin
                    valid_cnt++;
                    valid_cyc = cyc;
                    if (exp_blk.size() == 0) begin
                        chk("unexpected_ram_valid", 64'(ram_valid), 64'h0);
                    end else begin
                        b = exp_blk.pop_front();
                        for (int i = 0; i < 4; i++) begin
                            chk($sformatf("ram_data[%0d]", i), 64'(ram_data[i]), 64'(b[i*32 +: 32]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int a0;
        int v0;
        int wcnt;
        mem[10'h0A4] = 32'h11;        mem[10'h0A5] = 32'h22;
        mem[10'h0A6] = 32'h33;        mem[10'h0A7] = 32'h44;
        mem[10'h1F8] = 32'hA0;        mem[10'h1F9] = 32'hA1;
        mem[10'h1FA] = 32'hA2;        mem[10'h1FB] = 32'hA3;
        mem[10'h2C0] = 32'hC0DE0000;  mem[10'h2C1] = 32'hC0DE0001;
        mem[10'h2C2] = 32'hC0DE0002;  mem[10'h2C3] = 32'hC0DE0003;
        mem[10'h300] = 32'h55555555;  mem[10'h301] = 32'h66666666;
        mem[10'h302] = 32'h77777777;  mem[10'h303] = 32'h88888888;
        reset_n = 1'b0;
        prop_address = 10'h0;
        prop_read_en = 1'b0;
        prop_write_data = 32'h0;
        prop_write_en = 1'b0;
        tick();
        tick();
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_ram_valid", 64'(ram_valid), 64'h0);
        chk("reset_mem_en", 64'({mem_read_en, mem_write_en}), 64'h0);
        chk("reset_mem_address", 64'(mem_address), 64'h0);
        chk("reset_mem_write_data", 64'(mem_write_data), 64'h0);
        chk_block_zero("reset_ram_data");
        reset_n = 1'b1;
        tick();

        // Read 0x0A6, latency 1, read held through HOLD to confirm it waits for IDLE.
        lat = 1;
        tick();
        n0 = cyc;
        prop_address = 10'h0A6;
        prop_read_en = 1'b1;
        push_read(10'h0A4, {32'h44, 32'h33, 32'h22, 32'h11});
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k <= 4) chk($sformatf("rd1_read_en_k%0d", k), 64'(mem_read_en), 64'h1);
            if (k == 5) chk("rd1_read_en_k5", 64'(mem_read_en), 64'h0);
            if (k == 6) chk("rd1_ram_valid_k6", 64'(ram_valid), 64'h1);
            if (k == 7) chk("rd1_valid_cycle", 64'(valid_cyc), 64'(n0 + 6));
            if (k == 7 || k == 8) begin
                chk($sformatf("rd1_hold_busy_k%0d", k), 64'(busy), 64'h1);
                chk($sformatf("rd1_hold_noreq_k%0d", k), 64'(mem_read_en), 64'h0);
                chk($sformatf("rd1_hold_valid_k%0d", k), 64'(ram_valid), 64'h0);
            end
            if (k == 9) begin
                chk("rd1_idle_busy_k9", 64'(busy), 64'h0);
                chk("rd1_idle_noreq_k9", 64'(mem_read_en), 64'h0);
                push_read(10'h0A4, {32'h44, 32'h33, 32'h22, 32'h11});
            end
            if (k == 10) begin
                chk("rd1_refetch_k10", 64'(mem_read_en), 64'h1);
                prop_read_en = 1'b0;
            end
        end
        wait_idle();
        chk("rd1_valid_pulses", 64'(valid_cnt), 64'h2);

        // Write 0x013 with mem_ready low for three cycles.
        tick();
        prop_address = 10'h013;
        prop_write_data = 32'hDEADBEEF;
        prop_write_en = 1'b1;
        exp_req.push_back('{wr: 1'b1, addr: 10'h013, data: 32'hDEADBEEF});
        ready_q.push_back(1'b0); ready_q.push_back(1'b0);
        ready_q.push_back(1'b0); ready_q.push_back(1'b1);
        wcnt = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            prop_write_en = 1'b0;
            if (mem_write_en) wcnt++;
            if (k == 5) chk("wr_idle_busy", 64'(busy), 64'h0);
        end
        chk("wr_enable_cycles", 64'(wcnt), 64'h4);

        // Write and read together: write goes first, read is taken in the next IDLE.
        tick();
        prop_address = 10'h1F9;
        prop_write_data = 32'h0BADF00D;
        prop_write_en = 1'b1;
        prop_read_en = 1'b1;
        exp_req.push_back('{wr: 1'b1, addr: 10'h1F9, data: 32'h0BADF00D});
        push_read(10'h1F8, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        tick();
        prop_write_en = 1'b0;
        chk("wr_rd_write_first", 64'({mem_write_en, mem_read_en}), 64'h2);
        tick();
        chk("wr_rd_idle_between", 64'(busy), 64'h0);
        tick();
        chk("wr_rd_fetch_next", 64'({mem_write_en, mem_read_en}), 64'h1);
        prop_read_en = 1'b0;
        wait_idle();

        // Latency 3 with mem_ready toggling.
        lat = 3;
        a0 = acc_cnt;
        v0 = valid_cnt;
        tick();
        prop_address = 10'h2C3;
        prop_read_en = 1'b1;
        push_read(10'h2C0, {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000});
        for (int i = 0; i < 4; i++) begin
            ready_q.push_back(1'b1);
            ready_q.push_back(1'b0);
        end
        tick();
        prop_read_en = 1'b0;
        wait_idle();
        chk("tog_requests", 64'(acc_cnt - a0), 64'h4);
        chk("tog_valid_pulses", 64'(valid_cnt - v0), 64'h1);
        chk("tog_queue_empty", 64'(exp_req.size()), 64'h0);

        // Reset in the middle of a fetch; late responses must not land.
        tick();
        prop_address = 10'h301;
        prop_read_en = 1'b1;
        push_read(10'h300, {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555});
        tick();
        prop_read_en = 1'b0;
        tick();
        tick();
        chk("rst_mid_busy_before", 64'(busy), 64'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'h0);
        chk("rst_mid_mem_en", 64'({mem_read_en, mem_write_en}), 64'h0);
        chk("rst_mid_mem_address", 64'(mem_address), 64'h0);
        chk("rst_mid_ram_valid", 64'(ram_valid), 64'h0);
        chk_block_zero("rst_mid_ram_data");
        exp_req.delete();
        exp_blk.delete();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("rst_late_pending_drained", 64'(pend.size()), 64'h0);
        chk("rst_late_busy", 64'(busy), 64'h0);
        chk("rst_late_noreq", 64'(mem_read_en), 64'h0);
        chk_block_zero("rst_late_ram_data");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-service engine directly downstream of the cache. Accepts the cache's propagated read/write requests, performs single-word write-through to a word-wide memory port, and fetches whole blocks (BLOCK_SIZE words) for read misses. A completed block is delivered to the cache as a parallel array with a one-cycle `ram_valid` strobe.

## Interface
- RAM_ADDRESS_BITS, 10, word address width
- DATA_BITS, 32, word width
- BLOCK_BITS, 2, log2 words per block; BLOCK_SIZE = 2**BLOCK_BITS
- HOLD_CYCLES, 2, cycles after delivery during which new requests are ignored (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- prop_address  in  RAM_ADDRESS_BITS  request word address from cache
- prop_read_en  in  1  read-miss request
- prop_write_data  in  DATA_BITS  write data
- prop_write_en  in  1  write request
- ram_valid  out  1  block delivered, one-cycle pulse
- ram_data  out  DATA_BITS × [BLOCK_SIZE-1:0] (unpacked)  fetched block, index = word offset
- busy  out  1  high in every state except IDLE
- mem_address  out  RAM_ADDRESS_BITS  memory request address
- mem_read_en  out  1  memory read request
- mem_write_en  out  1  memory write request
- mem_write_data  out  DATA_BITS  memory write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read response valid (in order)
- mem_rdata  in  DATA_BITS  read response data

## Operation
- States: IDLE, WRITE, FETCH, DONE, HOLD.
- IDLE: requests sampled only here. prop_write_en has priority: capture address/data → WRITE. Else prop_read_en: capture block base (offset bits zeroed) → FETCH; clear req_cnt, rsp_cnt. mem_rvalid ignored.
- WRITE: mem_write_en=1, mem_address/mem_write_data = captured values, held until mem_ready → IDLE. A still-asserted read is then serviced from IDLE.
- FETCH: mem_read_en=1 while req_cnt < BLOCK_SIZE; mem_address = base | req_cnt; req_cnt increments on mem_read_en & mem_ready. Each mem_rvalid writes mem_rdata to ram_data[rsp_cnt], rsp_cnt increments. When last response (rsp_cnt = BLOCK_SIZE-1) arrives → DONE. Counters are BLOCK_BITS+1 wide; no wrap.
- Responses arrive earliest the cycle after acceptance; outstanding ≤ BLOCK_SIZE. mem_rvalid with no outstanding request ignored.
- DONE: ram_valid=1 for exactly one cycle → HOLD.
- HOLD: ignore all requests for HOLD_CYCLES cycles (covers cache registering ram_valid and filling) → IDLE.
- ram_data holds last block until overwritten word-by-word by the next fetch.
- Reset (any time, asynchronous): state IDLE, counters 0, ram_data all '0, all outputs 0. In-flight memory responses after reset ignored.

## Timing
- Reset values: ram_valid 0, ram_data '0, busy 0, mem_address '0, mem_read_en 0, mem_write_en 0, mem_write_data '0.
- All outputs registered or decoded from registered state; no prop_* → mem_* combinational path.
- Read, mem_ready=1, 1-cycle memory latency: request sampled cycle N; mem_read_en N+1..N+4; mem_rvalid N+2..N+5; ram_valid N+6; HOLD N+7..N+8; IDLE N+9.
- Write, mem_ready=1: sampled N; mem_write_en N+1; IDLE N+2.
- mem_ready low: request held stable, address unchanged.
- Simultaneous read and write in IDLE: write first, read next IDLE cycle.

## Structure
- Shared package cache_pkg: refill_state_t enum, BLOCK_SIZE derivation, block-base helper (zero offset bits).
- One sub-module natural: cache_refill_buffer (BLOCK_SIZE×DATA_BITS register array, indexed write port, clear on reset, parallel read out).

## Test plan
- Read 0x0A6, memory[0x0A4..0x0A7]=0x11,0x22,0x33,0x44, ready=1, latency 1 → mem_address 0x0A4..0x0A7, ram_valid pulse at N+6, ram_data[0..3]=0x11,0x22,0x33,0x44.
- Write 0x013 data 0xDEADBEEF, mem_ready low 3 cycles → mem_write_en held 4 cycles, address/data stable, IDLE 1 cycle after ready.
- Write and read both asserted in IDLE → write completes first, then block fetch of read address.
- Read with latency 3 and mem_ready toggling 1,0,1,0 → exactly 4 requests, 4 responses stored in order, single ram_valid pulse.
- prop_read_en held high through HOLD → no new fetch until IDLE; reset_n low mid-FETCH → outputs zero immediately, late mem_rvalid ignored, ram_data '0.
